instruction_fetch_decode: RTL and testbench

//  Fetch/decode stage between InstructionMemory and Execution. Owns the program

---
 rtl/instruction_fetch_decode_if.sv | 31 +++
 rtl/instruction_fetch_decode.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch_decode.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_decode_if.sv
// Bus between the fetch/decode stage and its neighbours: instruction memory
// read port, the decoded-instruction handshake to Execution, and start/halt control.
interface instruction_fetch_decode_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [255:0]      imem_data;
    logic              dec_valid;
    logic              dec_ready;
    logic [7:0]        dec_opcode;
    logic [7:0]        dec_dest;
    logic [7:0]        dec_src1;
    logic [7:0]        dec_src2;
    logic              dec_is_int;
    logic [ADDR_W-1:0] dec_pc;
    logic              halted;

    modport master (
        input  start, imem_data, dec_ready,
        output imem_rd, imem_addr, dec_valid, dec_opcode, dec_dest, dec_src1,
               dec_src2, dec_is_int, dec_pc, halted
    );

    modport slave (
        output start, imem_data, dec_ready,
        input  imem_rd, imem_addr, dec_valid, dec_opcode, dec_dest, dec_src1,
               dec_src2, dec_is_int, dec_pc, halted
    );
endinterface

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode stage: owns the PC, reads instruction memory, buffers returned
// words in a small FIFO and hands split fields to Execution until STOP is consumed.
module instruction_fetch_decode #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_START = {ADDR_W{1'b0}},
    parameter int                DEPTH    = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    instruction_fetch_decode_if.master  bus
);
    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CNT_W   = PTR_W + 1;
    localparam logic [7:0] OP_STOP = 8'hFF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] ret_pc_r;
    logic              inflight_r;
    logic [31:0]       instr_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  occ_s;
    logic [31:0]       head_s;
    logic              ret_valid_s;
    logic              ret_stop_s;
    logic              enq_s;
    logic              deq_s;
    logic              stop_hs_s;
    logic              rd_s;
    logic              full_s;
    logic              empty_s;
    logic              unused_s;

    // Returns only count while fetching, so the read racing a STOP return and
    // any read issued before a reset are dropped on arrival.
    assign ret_valid_s = inflight_r && (state_r == ST_FETCH);
    assign ret_stop_s  = ret_valid_s && (bus.imem_data[31:24] == OP_STOP);
    assign enq_s       = ret_valid_s;
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign deq_s       = !empty_s && bus.dec_ready;
    assign occ_s       = count_r + CNT_W'(inflight_r);
    assign head_s      = instr_mem_r[rd_ptr_r];
    assign stop_hs_s   = deq_s && (state_r == ST_DRAIN) && (head_s[31:24] == OP_STOP);
    assign unused_s    = ^bus.imem_data[255:32];

    assign bus.imem_addr  = pc_r;
    assign bus.dec_opcode = head_s[31:24];
    assign bus.dec_dest   = head_s[23:16];
    assign bus.dec_src1   = head_s[15:8];
    assign bus.dec_src2   = head_s[7:0];
    assign bus.dec_is_int = head_s[28];
    assign bus.dec_pc     = pc_mem_r[rd_ptr_r];

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH:  if (ret_stop_s) state_next_s = ST_DRAIN;  else state_next_s = ST_FETCH;
            ST_DRAIN:  if (stop_hs_s)  state_next_s = ST_HALTED; else state_next_s = ST_DRAIN;
            ST_HALTED: if (bus.start)  state_next_s = ST_FETCH;  else state_next_s = ST_HALTED;
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // Outputs: reads are throttled so buffered plus in-flight words never exceed DEPTH
    always_comb begin
        rd_s          = 1'b0;
        bus.halted    = 1'b0;
        bus.dec_valid = !empty_s;
        case (state_r)
            ST_FETCH:  rd_s = !Reset && !ret_stop_s && (occ_s < CNT_W'(DEPTH));
            ST_DRAIN:  rd_s = 1'b0;
            ST_HALTED: bus.halted = 1'b1;
            default:   rd_s = 1'b0;
        endcase
        bus.imem_rd = rd_s;
    end

    // PC and in-flight tracking
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r       <= PC_START;
            ret_pc_r   <= PC_START;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_s;
            if (rd_s) begin
                pc_r     <= pc_r + ADDR_W'(1'b1);
                ret_pc_r <= pc_r;
            end else if ((state_r == ST_HALTED) && bus.start) begin
                pc_r <= PC_START;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge Clk) begin
        if (enq_s) begin
            instr_mem_r[wr_ptr_r] <= bus.imem_data[31:0];
            pc_mem_r[wr_ptr_r]    <= ret_pc_r;
        end
    end

    instruction_fetch_decode_chk u_chk (
        .clk  (Clk),
        .rst  (Reset),
        .enq  (enq_s),
        .deq  (deq_s),
        .full (full_s)
    );
endmodule

// Flags a write into a full decode FIFO that is not freed by a same-cycle read.
module instruction_fetch_decode_chk (
    input logic clk,
    input logic rst,
    input logic enq,
    input logic deq,
    input logic full
);
    fifo_overflow_a: assert property (@(posedge clk) disable iff (rst) !(enq && full && !deq));
endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Directed bench for instruction_fetch_decode: reset, program run to STOP,
// back-pressure, reset in DRAIN, restart from HALTED and PC wrap-around.
module tb_instruction_fetch_decode;
    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    instruction_fetch_decode_if #(.ADDR_W(16)) bus ();
    instruction_fetch_decode_if #(.ADDR_W(16)) bus2 ();

    instruction_fetch_decode #(.ADDR_W(16), .PC_START(16'h0000), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );
    instruction_fetch_decode #(.ADDR_W(16), .PC_START(16'hFFFE), .DEPTH(4)) dut2 (
        .Clk(Clk), .Reset(Reset), .bus(bus2)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [16];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    int          stop_cyc = -1;
    logic [48:0] hs_q [$];
    logic [15:0] addr2_q [$];

    assign bus2.imem_data = 256'd0;
    assign bus2.dec_ready = 1'b1;
    assign bus2.start     = 1'b0;

    // Memory model (1-cycle read latency) and handshake/address monitors
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (bus.imem_rd) begin
            bus.imem_data <= {224'd0, mem[bus.imem_addr[3:0]]};
            rd_cnt        <= rd_cnt + 1;
        end else begin
            bus.imem_data <= 256'd0;
        end
        if (!Reset && bus.dec_valid && bus.dec_ready) begin
            hs_q.push_back({bus.dec_is_int, bus.dec_pc, bus.dec_opcode,
                            bus.dec_dest, bus.dec_src1, bus.dec_src2});
            if (bus.dec_opcode == 8'hFF) stop_cyc <= cyc;
        end
        if (bus2.imem_rd && addr2_q.size() < 4) addr2_q.push_back(bus2.imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_halt(input int max, output int seen);
        seen = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge Clk);
            if (bus.halted) begin
                seen = cyc;
                break;
            end
        end
        chk("halt_reached", bus.halted, 1'b1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        chk("start_halted", bus.halted, 1'b0);
        chk("start_addr", bus.imem_addr, 16'h0000);
    endtask

    task automatic check_hs(input int idx, input logic [15:0] pc, input logic [31:0] word);
        logic [48:0] e;
        if (idx < hs_q.size()) e = hs_q[idx];
        else e = {49{1'b1}};
        chk("hs_pc", e[47:32], pc);
        chk("hs_word", e[31:0], word);
        chk("hs_is_int", e[48], word[28]);
    endtask

    task automatic load_prog_a();
        mem[0] = 32'h01020304;
        mem[1] = 32'h11050607;
        mem[2] = 32'hFF000000;
        for (int i = 3; i < 16; i++) mem[i] = {8'hA0, 8'(i), 16'h0000};
    endtask

    initial begin
        int hc;
        int r0;
        bus.start     = 1'b0;
        bus.dec_ready = 1'b1;
        load_prog_a();

        // Reset held 3 cycles
        tick(3);
        chk("rst_imem_rd", bus.imem_rd, 1'b0);
        chk("rst_dec_valid", bus.dec_valid, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 16'h0000);

        // Program 01/11/FF with dec_ready=1, checking fill latency
        hs_q.delete();
        r0 = rd_cnt;
        Reset = 1'b0;
        #1;
        chk("first_rd", bus.imem_rd, 1'b1);
        chk("first_addr", bus.imem_addr, 16'h0000);
        @(negedge Clk);
        chk("lat_valid0", bus.dec_valid, 1'b0);
        @(negedge Clk);
        chk("lat_valid1", bus.dec_valid, 1'b1);
        chk("lat_opcode", bus.dec_opcode, 8'h01);
        wait_halt(30, hc);
        chk("p1_hs_count", hs_q.size(), 3);
        check_hs(0, 16'h0000, 32'h01020304);
        check_hs(1, 16'h0001, 32'h11050607);
        check_hs(2, 16'h0002, 32'hFF000000);
        chk("p1_is_int0", hs_q.size() > 0 ? hs_q[0][48] : 1'bx, 1'b0);
        chk("p1_is_int1", hs_q.size() > 1 ? hs_q[1][48] : 1'bx, 1'b1);
        chk("halt_delay", hc, stop_cyc + 1);
        chk("p1_reads", rd_cnt - r0, 3);
        tick(3);
        chk("halt_hold", bus.halted, 1'b1);
        chk("halt_valid", bus.dec_valid, 1'b0);
        chk("halt_no_rd", rd_cnt - r0, 3);

        // Back-pressure: 8 words then STOP, dec_ready low for 10 cycles
        for (int i = 0; i < 8; i++) mem[i] = {8'(8'h20 + i), 8'(i), 8'hA5, 8'h5A};
        mem[8] = 32'hFF123456;
        hs_q.delete();
        bus.dec_ready = 1'b0;
        r0 = rd_cnt;
        pulse_start();
        tick(9);
        chk("stall_reads", rd_cnt - r0, 4);
        chk("stall_rd_low", bus.imem_rd, 1'b0);
        chk("stall_valid", bus.dec_valid, 1'b1);
        chk("stall_head_pc", bus.dec_pc, 16'h0000);
        chk("stall_head_op", bus.dec_opcode, 8'h20);
        chk("stall_no_hs", hs_q.size(), 0);
        bus.dec_ready = 1'b1;
        wait_halt(40, hc);
        chk("p2_hs_count", hs_q.size(), 9);
        for (int i = 0; i < 8; i++) check_hs(i, 16'(i), {8'(8'h20 + i), 8'(i), 8'hA5, 8'h5A});
        check_hs(8, 16'h0008, 32'hFF123456);

        // Reset while draining 3 buffered words
        load_prog_a();
        hs_q.delete();
        bus.dec_ready = 1'b0;
        pulse_start();
        tick(6);
        chk("drain_valid", bus.dec_valid, 1'b1);
        chk("drain_rd", bus.imem_rd, 1'b0);
        chk("drain_halted", bus.halted, 1'b0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_drain_valid", bus.dec_valid, 1'b0);
        chk("rst_drain_addr", bus.imem_addr, 16'h0000);
        chk("rst_drain_rd", bus.imem_rd, 1'b0);
        Reset = 1'b0;
        bus.dec_ready = 1'b1;
        wait_halt(30, hc);
        chk("p3_hs_count", hs_q.size(), 3);
        check_hs(0, 16'h0000, 32'h01020304);
        check_hs(1, 16'h0001, 32'h11050607);
        check_hs(2, 16'h0002, 32'hFF000000);

        // Restart from HALTED re-executes the program
        hs_q.delete();
        pulse_start();
        wait_halt(30, hc);
        chk("p4_hs_count", hs_q.size(), 3);
        check_hs(0, 16'h0000, 32'h01020304);
        check_hs(2, 16'h0002, 32'hFF000000);

        // PC wrap on the second instance
        chk("wrap_count", addr2_q.size(), 4);
        chk("wrap_a0", addr2_q.size() > 0 ? addr2_q[0] : 16'hxxxx, 16'hFFFE);
        chk("wrap_a1", addr2_q.size() > 1 ? addr2_q[1] : 16'hxxxx, 16'hFFFF);
        chk("wrap_a2", addr2_q.size() > 2 ? addr2_q[2] : 16'hxxxx, 16'h0000);
        chk("wrap_a3", addr2_q.size() > 3 ? addr2_q[3] : 16'hxxxx, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
